morse_playback: RTL

//  Reader for the Morse storage path: on Enter it replays up to three stored 10-bit letter codes as timed tone.
//  The letter codes come from the storage block's store_seqs bus. Output tone drives buzzer/LED.
//  Dot=1 unit on, dash=3 on; 1 unit off between symbols, 3 units between letters, 7 units for a word space.

---
 rtl/morse_pkg.sv | 36 +++
 rtl/morse_unit_timer.sv | 52 +++++
 rtl/morse_playback.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared encodings for the Morse playback path: symbol codes, unit
// durations for tones and silences, and the playback FSM state encoding.
package morse_pkg;

  // Width of the unit down-counter; the longest interval is 7 units.
  localparam int UNIT_CNT_W = 3;

  // Two-bit symbol codes packed five to a letter, first symbol in the MSBs.
  typedef enum logic [1:0] {
    SYM_END  = 2'b00,
    SYM_DOT  = 2'b01,
    SYM_DASH = 2'b10,
    SYM_WSP  = 2'b11
  } sym_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TONE,
    ST_GAP,
    ST_DONE
  } state_e;

  // Durations in Morse units.
  localparam logic [UNIT_CNT_W-1:0] UNITS_DOT        = 3'd1;
  localparam logic [UNIT_CNT_W-1:0] UNITS_DASH       = 3'd3;
  localparam logic [UNIT_CNT_W-1:0] UNITS_SYM_GAP    = 3'd1;
  localparam logic [UNIT_CNT_W-1:0] UNITS_LETTER_GAP = 3'd3;
  localparam logic [UNIT_CNT_W-1:0] UNITS_WORD_GAP   = 3'd7;

  // Tone length for a dot or dash symbol.
  function automatic logic [UNIT_CNT_W-1:0] tone_units(input logic [1:0] sym);
    return (sym == SYM_DASH) ? UNITS_DASH : UNITS_DOT;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Interval timer counting whole Morse units. A load restarts the prescaler
// and sets the unit down-counter; expire_o is high during the final cycle
// of the loaded interval, so an interval of N units lasts N*UNIT_CYCLES cycles.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  load_i,
  input  logic [UNIT_CNT_W-1:0] units_i,
  output logic                  expire_o
);

  localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(UNIT_CYCLES - 1);

  logic [PW-1:0]         pre_q, pre_d;
  logic [UNIT_CNT_W-1:0] cnt_q, cnt_d;

  // Prescaler wraps every unit; the unit counter steps down on each wrap.
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load_i) begin
      pre_d = '0;
      cnt_d = units_i - 3'd1;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 3'd1;
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  // Timer registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (Reset) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (pre_q == PRE_LAST) && (cnt_q == '0);

endmodule

// File: rtl/morse_playback.sv
// Replays up to three latched letter codes as a timed Morse tone.
// The FSM walks a shifted copy of the current letter; the top two bits are
// always the symbol playing or pending. Empty letters are skipped by a
// combinational search, so no silence is added for them.
module morse_playback
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 10,
  parameter int SEQ_W       = 10,
  parameter int NUM_SEQS    = 3
) (
  input  logic                      clk,
  input  logic                      Reset,
  input  logic                      start,
  input  logic [SEQ_W*NUM_SEQS-1:0] store_seqs,
  input  logic [1:0]                seq_count,
  output logic                      tone,
  output logic                      dot_active,
  output logic                      dash_active,
  output logic                      busy,
  output logic [1:0]                cur_seq,
  output logic                      done
);

  localparam int SYMS = SEQ_W / 2;
  localparam logic [2:0] LAST_IDX = 3'(SYMS - 1);

  state_e                    state_q, state_d;
  logic [SEQ_W*NUM_SEQS-1:0] seqs_q, seqs_d;
  logic [1:0]                count_q, count_d;
  logic [1:0]                cur_q, cur_d;
  logic [SEQ_W-1:0]          letter_q, letter_d;
  logic [2:0]                idx_q, idx_d;
  logic                      tone_q, dot_q, dash_q, busy_q, done_q;

  logic                  tmr_load;
  logic [UNIT_CNT_W-1:0] tmr_units;
  logic                  tmr_expire;

  logic [1:0]       search_start;
  logic             next_found;
  logic [1:0]       next_sel;
  logic [SEQ_W-1:0] next_letter;
  logic [1:0]       shifted_sym;
  logic [1:0]       pending_sym;
  logic [1:0]       first_sym;
  logic             take_next;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .Reset   (Reset),
    .load_i  (tmr_load),
    .units_i (tmr_units),
    .expire_o(tmr_expire)
  );

  // Find the lowest-indexed non-empty letter at or after the search start.
  always_comb begin
    search_start = (state_q == ST_LOAD) ? 2'd0 : cur_q + 2'd1;
    next_found   = 1'b0;
    next_sel     = 2'd0;
    next_letter  = '0;
    for (int j = NUM_SEQS - 1; j >= 0; j--) begin
      if ((j >= int'(search_start)) && (j < int'(count_q)) &&
          (seqs_q[SEQ_W*(NUM_SEQS-j)-1 -: 2] != SYM_END)) begin
        next_found  = 1'b1;
        next_sel    = 2'(j);
        next_letter = seqs_q[SEQ_W*(NUM_SEQS-j)-1 -: SEQ_W];
      end
    end
  end

  // Next-state logic: symbol sequencing, gap selection and timer loads.
  always_comb begin
    state_d   = state_q;
    seqs_d    = seqs_q;
    count_d   = count_q;
    cur_d     = cur_q;
    letter_d  = letter_q;
    idx_d     = idx_q;
    tmr_load  = 1'b0;
    tmr_units = UNITS_DOT;
    take_next = 1'b0;

    shifted_sym = (idx_q >= LAST_IDX) ? SYM_END : letter_q[SEQ_W-3 -: 2];
    pending_sym = (idx_q > LAST_IDX) ? SYM_END : letter_q[SEQ_W-1 -: 2];
    first_sym   = next_letter[SEQ_W-1 -: 2];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          seqs_d   = store_seqs;
          count_d  = (int'(seq_count) > NUM_SEQS) ? 2'(NUM_SEQS) : seq_count;
          cur_d    = 2'd0;
          tmr_load = 1'b1;
        end
      end
      ST_LOAD: begin
        take_next = 1'b1;
      end
      ST_TONE: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          letter_d = letter_q << 2;
          idx_d    = idx_q + 3'd1;
          case (shifted_sym)
            SYM_DOT, SYM_DASH: begin
              state_d   = ST_GAP;
              tmr_units = UNITS_SYM_GAP;
            end
            SYM_WSP: begin
              state_d   = ST_GAP;
              tmr_units = UNITS_WORD_GAP;
              letter_d  = letter_q << 4;
              idx_d     = idx_q + 3'd2;
            end
            default: begin
              if (next_found) begin
                state_d   = ST_GAP;
                tmr_units = UNITS_LETTER_GAP;
              end else begin
                state_d = ST_DONE;
              end
            end
          endcase
        end
      end
      ST_GAP: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          case (pending_sym)
            SYM_DOT, SYM_DASH: begin
              state_d   = ST_TONE;
              tmr_units = tone_units(pending_sym);
            end
            SYM_WSP: begin
              state_d   = ST_GAP;
              tmr_units = UNITS_WORD_GAP;
              letter_d  = letter_q << 2;
              idx_d     = idx_q + 3'd1;
            end
            default: begin
              take_next = 1'b1;
            end
          endcase
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        tmr_load = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (take_next) begin
      tmr_load = 1'b1;
      if (next_found) begin
        cur_d = next_sel;
        if (first_sym == SYM_WSP) begin
          state_d   = ST_GAP;
          tmr_units = UNITS_WORD_GAP;
          letter_d  = next_letter << 2;
          idx_d     = 3'd1;
        end else begin
          state_d   = ST_TONE;
          tmr_units = tone_units(first_sym);
          letter_d  = next_letter;
          idx_d     = 3'd0;
        end
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  // State, latched letters and registered outputs, all cleared by Reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      seqs_q   <= '0;
      count_q  <= '0;
      cur_q    <= '0;
      letter_q <= '0;
      idx_q    <= '0;
      tone_q   <= 1'b0;
      dot_q    <= 1'b0;
      dash_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seqs_q   <= seqs_d;
      count_q  <= count_d;
      cur_q    <= cur_d;
      letter_q <= letter_d;
      idx_q    <= idx_d;
      tone_q   <= (state_q == ST_TONE);
      dot_q    <= (state_q == ST_TONE) && (letter_q[SEQ_W-1 -: 2] == SYM_DOT);
      dash_q   <= (state_q == ST_TONE) && (letter_q[SEQ_W-1 -: 2] == SYM_DASH);
      busy_q   <= (state_d == ST_LOAD) || (state_d == ST_TONE) || (state_d == ST_GAP);
      done_q   <= (state_q == ST_DONE);
    end
  end

  assign tone        = tone_q;
  assign dot_active  = dot_q;
  assign dash_active = dash_q;
  assign busy        = busy_q;
  assign cur_seq     = cur_q;
  assign done        = done_q;

endmodule
